// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states and default framing constants
// used by the receiver, transmitter and baud generator.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned DATA_BITS_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a
// selectable reset value so idle-high lines come out of reset idle.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver on an oversampling clock: mid-bit sampling of a
// synchronised rx, one-cycle valid / frame_err pulses, held data output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk_baud,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = $clog2(DATA_BITS) + 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_rx (
    .clk   (clk_baud),
    .rst_n (rst),
    .d     (rx),
    .q     (rx_s)
  );

  // Next-state and output logic; every state change clears cnt and bit_idx.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end
        START: begin
          if (cnt_q == CNT_HALF) begin
            state_d = rx_s ? IDLE : DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            if (idx_q == IDX_LAST) begin
              state_d = STOP;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          // Leave at mid stop bit so an immediately following start is seen.
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            if (rx_s) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_baud or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = busy_q;

endmodule
